// File: rtl/knn_label_fetch.sv
// Resolves k-best buffer sample indices into class labels and streams them to
// majority voting over a valid/ready handshake.
module knn_label_fetch #(
   parameter int unsigned K           = 5,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned LABEL_WIDTH = 4,
   localparam int unsigned KW = (K > 1) ? $clog2(K) : 1,
   localparam int unsigned CW = $clog2(K + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [CW-1:0]          k_value,
   input  logic [CW-1:0]          num_neighbors,
   output logic                   kbest_ren,
   output logic [KW-1:0]          kbest_raddr,
   input  logic [ADDR_WIDTH-1:0]  kbest_rdata_q,
   output logic                   label_ren,
   output logic [ADDR_WIDTH-1:0]  label_raddr,
   input  logic [LABEL_WIDTH-1:0] label_rdata_q,
   output logic                   label_valid,
   output logic [LABEL_WIDTH-1:0] label_data,
   input  logic                   label_ready,
   output logic                   busy,
   output logic                   done,
   output logic [CW-1:0]          fetched_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_KB = 3'd1,
      WT_KB = 3'd2,
      RD_LB = 3'd3,
      WT_LB = 3'd4,
      EMIT  = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t                 state_q, state_d;
   logic [KW-1:0]          idx_q, idx_d;
   logic [ADDR_WIDTH-1:0]  sidx_q, sidx_d;
   logic [CW-1:0]          n_eff_q, n_eff_d;
   logic [CW-1:0]          count_d;
   logic [LABEL_WIDTH-1:0] data_d;
   logic [CW-1:0]          k_lim, n_min;

   logic                   kbest_ren_d, label_ren_d, label_valid_d, busy_d, done_d;
   logic [KW-1:0]          kbest_raddr_d;
   logic [ADDR_WIDTH-1:0]  label_raddr_d;

   // Effective neighbour count: min(k_value, num_neighbors, K) at CW width
   always_comb begin
      k_lim = (k_value < num_neighbors) ? k_value : num_neighbors;
      n_min = (k_lim < CW'(K)) ? k_lim : CW'(K);
   end

   // Next state, datapath updates and next-cycle output decode
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sidx_d  = sidx_q;
      n_eff_d = n_eff_q;
      count_d = fetched_count;
      data_d  = label_data;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               n_eff_d = n_min;
               idx_d   = '0;
               count_d = '0;
               state_d = (n_min == '0) ? DONE : RD_KB;
            end
         end
         RD_KB: state_d = WT_KB;
         WT_KB: begin
            sidx_d  = kbest_rdata_q;
            state_d = RD_LB;
         end
         RD_LB: state_d = WT_LB;
         WT_LB: begin
            data_d  = label_rdata_q;
            state_d = EMIT;
         end
         EMIT: begin
            if (label_ready) begin
               count_d = CW'(fetched_count + 1'b1);
               idx_d   = KW'(idx_q + 1'b1);
               state_d = (CW'(fetched_count + 1'b1) == n_eff_q) ? DONE : RD_KB;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A transfer coinciding with abort still counts; only the sequencing stops
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end

      busy_d        = (state_d != IDLE);
      done_d        = (state_d == DONE);
      label_valid_d = (state_d == EMIT);
      kbest_ren_d   = (state_d == RD_KB);
      label_ren_d   = (state_d == RD_LB);
      kbest_raddr_d = kbest_ren_d ? idx_d : '0;
      label_raddr_d = label_ren_d ? sidx_d : '0;
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         sidx_q        <= '0;
         n_eff_q       <= '0;
         fetched_count <= '0;
         label_data    <= '0;
         label_valid   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         kbest_ren     <= 1'b0;
         kbest_raddr   <= '0;
         label_ren     <= 1'b0;
         label_raddr   <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         sidx_q        <= sidx_d;
         n_eff_q       <= n_eff_d;
         fetched_count <= count_d;
         label_data    <= data_d;
         label_valid   <= label_valid_d;
         busy          <= busy_d;
         done          <= done_d;
         kbest_ren     <= kbest_ren_d;
         kbest_raddr   <= kbest_raddr_d;
         label_ren     <= label_ren_d;
         label_raddr   <= label_raddr_d;
      end
   end

endmodule

// File: tb/tb_knn_label_fetch.sv
// Directed bench for knn_label_fetch: memory models, a label-stream scoreboard
// checked every cycle, and literal expectations for timing and sequences.
module tb_knn_label_fetch;
   localparam int unsigned K  = 5;
   localparam int unsigned AW = 8;
   localparam int unsigned LW = 4;
   localparam int unsigned KW = 3;
   localparam int unsigned CW = 3;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, label_ready;
   logic [CW-1:0] k_value, num_neighbors;
   logic          kbest_ren;
   logic [KW-1:0] kbest_raddr;
   logic [AW-1:0] kbest_rdata_q;
   logic          label_ren;
   logic [AW-1:0] label_raddr;
   logic [LW-1:0] label_rdata_q;
   logic          label_valid;
   logic [LW-1:0] label_data;
   logic          busy, done;
   logic [CW-1:0] fetched_count;

   knn_label_fetch #(.K(K), .ADDR_WIDTH(AW), .LABEL_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .k_value(k_value), .num_neighbors(num_neighbors),
      .kbest_ren(kbest_ren), .kbest_raddr(kbest_raddr), .kbest_rdata_q(kbest_rdata_q),
      .label_ren(label_ren), .label_raddr(label_raddr), .label_rdata_q(label_rdata_q),
      .label_valid(label_valid), .label_data(label_data), .label_ready(label_ready),
      .busy(busy), .done(done), .fetched_count(fetched_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int e_cyc = 0;
   int off;
   int done_snap;

   logic [AW-1:0] kb  [K];
   logic [LW-1:0] lbl [256];

   // Scoreboard: what the stream must look like for the current run
   int exp_kaddr[$];
   int exp_laddr[$];
   int exp_lbl[$];
   int got_kaddr[$];
   int got_laddr[$];
   int got_lbl[$];
   int m_cnt = 0;
   bit m_expect_done = 1'b0;
   int done_pulses = 0;
   bit prev_stall = 1'b0;
   logic [LW-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle-latency memories; garbage when not read
   always @(posedge clk) begin
      kbest_rdata_q <= kbest_ren ? kb[kbest_raddr] : AW'($urandom);
      label_rdata_q <= label_ren ? lbl[label_raddr] : LW'($urandom);
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic bad(input string name, input int act);
      tests++;
      fails++;
      $display("FAIL %s: got %0d expected none (t=%0t)", name, act, $time);
   endtask

   task automatic chk_list(input string name, input int got[$], input int ex[5], input int n);
      chk({name, "_len"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], ex[i]);
   endtask

   task automatic arm(input int kv, input int nn);
      int n;
      n = kv;
      if (nn < n) n = nn;
      if (int'(K) < n) n = int'(K);
      exp_kaddr.delete(); exp_laddr.delete(); exp_lbl.delete();
      got_kaddr.delete(); got_laddr.delete(); got_lbl.delete();
      for (int i = 0; i < n; i++) begin
         exp_kaddr.push_back(i);
         exp_laddr.push_back(int'(kb[i]));
         exp_lbl.push_back(int'(lbl[kb[i]]));
      end
      m_cnt = 0;
      m_expect_done = 1'b1;
   endtask

   task automatic flush();
      exp_kaddr.delete(); exp_laddr.delete(); exp_lbl.delete();
      m_expect_done = 1'b0;
   endtask

   // Per-cycle comparison against the scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_valid", int'(label_valid), 0);
         chk("rst_data", int'(label_data), 0);
         chk("rst_kren", int'(kbest_ren), 0);
         chk("rst_kaddr", int'(kbest_raddr), 0);
         chk("rst_lren", int'(label_ren), 0);
         chk("rst_laddr", int'(label_raddr), 0);
         chk("rst_count", int'(fetched_count), 0);
         prev_stall = 1'b0;
      end else begin
         if (kbest_ren) begin
            got_kaddr.push_back(int'(kbest_raddr));
            if (exp_kaddr.size() == 0) bad("kbest_ren_unexpected", int'(kbest_raddr));
            else chk("kbest_raddr", int'(kbest_raddr), exp_kaddr.pop_front());
         end else chk("kbest_raddr_idle", int'(kbest_raddr), 0);
         if (label_ren) begin
            got_laddr.push_back(int'(label_raddr));
            if (exp_laddr.size() == 0) bad("label_ren_unexpected", int'(label_raddr));
            else chk("label_raddr", int'(label_raddr), exp_laddr.pop_front());
         end else chk("label_raddr_idle", int'(label_raddr), 0);
         chk("fetched_count", int'(fetched_count), m_cnt);
         if (prev_stall) begin
            chk("stall_valid", int'(label_valid), 1);
            chk("stall_data", int'(label_data), int'(prev_data));
         end
         if (kbest_ren || label_ren || label_valid || done) chk("busy_active", int'(busy), 1);
         if (label_valid && label_ready) begin
            got_lbl.push_back(int'(label_data));
            if (exp_lbl.size() == 0) bad("transfer_unexpected", int'(label_data));
            else chk("label_data", int'(label_data), exp_lbl.pop_front());
            m_cnt++;
         end
         if (done) begin
            done_pulses++;
            if (!m_expect_done) bad("done_unexpected", done_pulses);
            else chk("done_all_labels", exp_lbl.size(), 0);
            m_expect_done = 1'b0;
         end
         prev_stall = label_valid && !label_ready;
         prev_data  = label_data;
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive start from IDLE; edge E is the accepting edge, cycle E+1 follows it
   task automatic start_run(input int kv, input int nn);
      k_value = CW'(kv);
      num_neighbors = CW'(nn);
      start = 1'b1;
      @(posedge clk);
      #1;
      e_cyc = cyc - 1;
      arm(kv, nn);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int o);
      o = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done) begin
            o = cyc - e_cyc;
            break;
         end
      end
      if (o < 0) bad("done_timeout", bound);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0t expected completion", $time);
      $fatal(1, "timeout");
   end

   initial begin
      kb = '{8'd7, 8'd3, 8'd12, 8'd0, 8'd9};
      for (int i = 0; i < 256; i++) lbl[i] = LW'(i * 7 + 3);
      lbl[7] = 4'd2; lbl[3] = 4'd2; lbl[12] = 4'd5; lbl[0] = 4'd1; lbl[9] = 4'd2;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; label_ready = 1'b1;
      k_value = '0; num_neighbors = '0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_edges(2);

      // Normal fetch
      start_run(5, 5);
      wait_done(100, off);
      chk("normal_done_cycle", off, 26);
      chk("normal_count", int'(fetched_count), 5);
      chk_list("normal_labels", got_lbl, '{2, 2, 5, 1, 2}, 5);
      chk_list("normal_kaddr", got_kaddr, '{0, 1, 2, 3, 4}, 5);
      chk_list("normal_laddr", got_laddr, '{7, 3, 12, 0, 9}, 5);
      wait_edges(2);
      chk("hold_count_after_done", int'(fetched_count), 5);

      // Clamp to num_neighbors
      start_run(5, 3);
      wait_done(100, off);
      chk("clamp3_done_cycle", off, 16);
      chk("clamp3_count", int'(fetched_count), 3);
      chk_list("clamp3_labels", got_lbl, '{2, 2, 5, 0, 0}, 3);
      wait_edges(2);

      // k_value = 0: immediate done, no reads
      start_run(0, 5);
      wait_done(20, off);
      chk("k0_done_cycle", off, 1);
      chk("k0_count", int'(fetched_count), 0);
      chk("k0_kreads", got_kaddr.size(), 0);
      chk("k0_lreads", got_laddr.size(), 0);
      wait_edges(2);

      // Backpressure on the 2nd label for cycles E+10..E+13
      start_run(5, 5);
      wait_edges(9);
      chk("bp_valid_at_stall", int'(label_valid), 1);
      label_ready = 1'b0;
      wait_edges(4);
      label_ready = 1'b1;
      wait_done(100, off);
      chk("bp_done_cycle", off, 30);
      chk("bp_count", int'(fetched_count), 5);
      chk_list("bp_labels", got_lbl, '{2, 2, 5, 1, 2}, 5);
      wait_edges(2);

      // Abort in WT_LB of the 3rd neighbour (cycle E+14)
      done_snap = done_pulses;
      start_run(5, 5);
      wait_edges(13);
      chk("abort_busy_before", int'(busy), 1);
      abort = 1'b1;
      wait_edges(1);
      abort = 1'b0;
      flush();
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(label_valid), 0);
      chk("abort_count", int'(fetched_count), 2);
      wait_edges(8);
      chk("abort_no_done", done_pulses, done_snap);
      chk("abort_count_hold", int'(fetched_count), 2);

      // Abort coinciding with the 2nd-label handshake (cycle E+10)
      start_run(5, 5);
      wait_edges(9);
      abort = 1'b1;
      wait_edges(1);
      abort = 1'b0;
      flush();
      @(negedge clk);
      chk("abort_hs_busy", int'(busy), 0);
      chk("abort_hs_count", int'(fetched_count), 2);
      wait_edges(8);
      chk("abort_hs_no_done", done_pulses, done_snap);

      // Abort and start together in IDLE: start dropped
      k_value = 3'd5; num_neighbors = 3'd5;
      start = 1'b1; abort = 1'b1;
      wait_edges(1);
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_start_idle_busy", int'(busy), 0);
      chk("abort_start_idle_count", int'(fetched_count), 2);
      wait_edges(3);

      // start while busy with a different k_value is ignored
      start_run(5, 5);
      wait_edges(3);
      k_value = 3'd1; num_neighbors = 3'd1;
      start = 1'b1;
      wait_edges(1);
      start = 1'b0;
      wait_done(100, off);
      chk("busy_start_done_cycle", off, 26);
      chk("busy_start_count", int'(fetched_count), 5);
      wait_edges(2);

      // Back-to-back: start held through DONE is accepted on the next IDLE cycle
      start_run(5, 2);
      wait_done(100, off);
      chk("b2b_first_done_cycle", off, 11);
      k_value = 3'd3; num_neighbors = 3'd5;
      start = 1'b1;
      @(posedge clk); #1;
      chk("b2b_idle_busy", int'(busy), 0);
      chk("b2b_idle_count", int'(fetched_count), 2);
      @(posedge clk); #1;
      e_cyc = cyc - 1;
      arm(3, 5);
      start = 1'b0;
      @(negedge clk);
      chk("b2b_count_cleared", int'(fetched_count), 0);
      wait_done(100, off);
      chk("b2b_done_cycle", off, 16);
      chk("b2b_count", int'(fetched_count), 3);
      chk_list("b2b_labels", got_lbl, '{2, 2, 5, 0, 0}, 3);
      wait_edges(2);

      // Reset during EMIT of the 1st label, then a clean full run
      start_run(5, 5);
      wait_edges(4);
      chk("rst_emit_valid_before", int'(label_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", int'(label_valid), 0);
      chk("rst_async_busy", int'(busy), 0);
      chk("rst_async_data", int'(label_data), 0);
      flush();
      m_cnt = 0;
      wait_edges(2);
      rst_n = 1'b1;
      wait_edges(1);
      start_run(5, 5);
      wait_done(100, off);
      chk("post_rst_done_cycle", off, 26);
      chk("post_rst_count", int'(fetched_count), 5);
      chk_list("post_rst_labels", got_lbl, '{2, 2, 5, 1, 2}, 5);
      wait_edges(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
